// File: rtl/feedback_tone_sequencer_if.sv
// Feedback tone sequencer interface.
// Groups the request pulses coming from the vending controller and the tone-request levels
// driven to the square-wave tone generator.
//   vend_pulse  : single-cycle request, successful vend
//   error_pulse : single-cycle request, error (bad coin, sold out)
//   vend_event  : level, vend tone must sound
//   error_event : level, error beep must sound
//   busy        : sequencer is not idle
//   mute        : (FEEDBACK_MUTE_EN only) forces both event outputs low
// master modport = requester/observer side, slave modport = sequencer side.
interface feedback_tone_sequencer_if;
  logic vend_pulse;
  logic error_pulse;
  logic vend_event;
  logic error_event;
  logic busy;
`ifdef FEEDBACK_MUTE_EN
  logic mute;

  modport master (
    output vend_pulse,
    output error_pulse,
    output mute,
    input  vend_event,
    input  error_event,
    input  busy
  );

  modport slave (
    input  vend_pulse,
    input  error_pulse,
    input  mute,
    output vend_event,
    output error_event,
    output busy
  );
`else
  modport master (
    output vend_pulse,
    output error_pulse,
    input  vend_event,
    input  error_event,
    input  busy
  );

  modport slave (
    input  vend_pulse,
    input  error_pulse,
    output vend_event,
    output error_event,
    output busy
  );
`endif
endinterface

// File: rtl/feedback_tone_sequencer.sv
// Feedback tone sequencer.
// Turns single-cycle vend/error pulses into timed, level-held tone requests: a vend pulse gives
// one long tone, an error pulse gives a burst of short beeps separated by silent gaps.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   io_fb : feedback_tone_sequencer_if.slave (pulses in, vend_event/error_event/busy out)
// Optional feature macro: FEEDBACK_MUTE_EN adds io_fb.mute, which masks both event outputs
// while leaving the sequencing (and busy) untouched.
// All outputs are registered; a pulse sampled at one edge is visible after the next edge.
module feedback_tone_sequencer #(
  parameter int unsigned CLOCK_HZ      = 100_000_000,
  parameter int unsigned VEND_MS       = 200,
  parameter int unsigned ERROR_BEEP_MS = 100,
  parameter int unsigned ERROR_GAP_MS  = 100,
  parameter int unsigned ERROR_BEEPS   = 3
) (
  input logic                          clk,
  input logic                          rst_n,
  feedback_tone_sequencer_if.slave     io_fb
);

  localparam logic [31:0] VEND_CYC = (CLOCK_HZ / 32'd1000) * VEND_MS;
  localparam logic [31:0] BEEP_CYC = (CLOCK_HZ / 32'd1000) * ERROR_BEEP_MS;
  localparam logic [31:0] GAP_CYC  = (CLOCK_HZ / 32'd1000) * ERROR_GAP_MS;

  // Terminal counts; a zero duration degenerates to a single cycle for tones.
  localparam logic [31:0] VEND_LAST = (VEND_CYC == 32'd0) ? 32'd0 : VEND_CYC - 32'd1;
  localparam logic [31:0] BEEP_LAST = (BEEP_CYC == 32'd0) ? 32'd0 : BEEP_CYC - 32'd1;
  localparam logic [31:0] GAP_LAST  = (GAP_CYC == 32'd0) ? 32'd0 : GAP_CYC - 32'd1;

  localparam int unsigned BeepW = $clog2(ERROR_BEEPS + 1);
  localparam logic [BeepW-1:0] BEEPS_N = BeepW'(ERROR_BEEPS);
  localparam logic [BeepW-1:0] BEEP_ONE = BeepW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StVendTone,
    StErrTone,
    StErrGap
  } state_e;

  state_e            r_state,        w_state_nxt;
  logic [31:0]       r_cnt,          w_cnt_nxt;
  logic [BeepW-1:0]  r_beep,         w_beep_nxt;
  logic              r_vend_pending, w_pending_nxt;
  logic              r_vend_event;
  logic              r_error_event;
  logic              r_busy;

  logic w_vend;
  logic w_err;
  logic w_mute;

  assign w_vend = io_fb.vend_pulse;
  assign w_err  = io_fb.error_pulse;

`ifdef FEEDBACK_MUTE_EN
  assign w_mute = io_fb.mute;
`else
  assign w_mute = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 32'd1;
    w_beep_nxt    = r_beep;
    w_pending_nxt = r_vend_pending;
    case (r_state)
      StIdle: begin
        w_cnt_nxt = 32'd0;
        if (w_err) begin
          w_state_nxt   = StErrTone;
          w_beep_nxt    = BEEP_ONE;
          w_pending_nxt = w_vend;
        end else if (w_vend) begin
          w_state_nxt = StVendTone;
        end
      end
      StVendTone: begin
        if (w_err) begin
          // Error preempts the vend tone; the vend is dropped, not deferred.
          w_state_nxt   = StErrTone;
          w_cnt_nxt     = 32'd0;
          w_beep_nxt    = BEEP_ONE;
          w_pending_nxt = 1'b0;
        end else if (w_vend) begin
          w_cnt_nxt = 32'd0;
        end else if (r_cnt == VEND_LAST) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 32'd0;
        end
      end
      StErrTone: begin
        if (w_vend) begin
          w_pending_nxt = 1'b1;
        end
        if (r_cnt == BEEP_LAST) begin
          w_cnt_nxt = 32'd0;
          if (r_beep < BEEPS_N) begin
            if (GAP_CYC == 32'd0) begin
              w_beep_nxt = r_beep + BEEP_ONE;
            end else begin
              w_state_nxt = StErrGap;
            end
          end else begin
            // Final beep ends without a gap; a vend seen this very cycle still counts.
            w_beep_nxt    = '0;
            w_pending_nxt = 1'b0;
            w_state_nxt   = (r_vend_pending || w_vend) ? StVendTone : StIdle;
          end
        end
      end
      StErrGap: begin
        if (w_vend) begin
          w_pending_nxt = 1'b1;
        end
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = StErrTone;
          w_cnt_nxt   = 32'd0;
          w_beep_nxt  = r_beep + BEEP_ONE;
        end
      end
      default: begin
        w_state_nxt   = StIdle;
        w_cnt_nxt     = 32'd0;
        w_beep_nxt    = '0;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_cnt          <= 32'd0;
      r_beep         <= '0;
      r_vend_pending <= 1'b0;
      r_vend_event   <= 1'b0;
      r_error_event  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_beep         <= w_beep_nxt;
      r_vend_pending <= w_pending_nxt;
      r_vend_event   <= (w_state_nxt == StVendTone) && !w_mute;
      r_error_event  <= (w_state_nxt == StErrTone) && !w_mute;
      r_busy         <= (w_state_nxt != StIdle);
    end
  end

  assign io_fb.vend_event  = r_vend_event;
  assign io_fb.error_event = r_error_event;
  assign io_fb.busy        = r_busy;

endmodule
